// File: rtl/dl11_uart_pkg.sv
// dl11_uart_pkg: shared state encodings and oversampling constants for the DL11 UART core
package dl11_uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int HALF_BIT = 8;
  localparam int DATA_BITS = 8;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
endpackage

// File: rtl/dl11_uart_tick_gen.sv
// uart_tick_gen: free-running divider emitting a one-cycle 16x oversample tick
module uart_tick_gen #(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt_q;
  assign tick = cnt_q == W'(CLK_DIV - 1);
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= tick ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/dl11_uart.sv
// dl11_uart: 8N1 serial core with 16x oversampled TX/RX and four-phase byte handshakes
module dl11_uart
  import dl11_uart_pkg::*;
#(
  parameter int CLK_DIV = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_tx_req,
  output logic       ld_tx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_enable,
  output logic       tx_out,
  output logic       tx_empty,
  input  logic       uld_rx_req,
  output logic       uld_rx_ack,
  output logic [7:0] rx_data,
  input  logic       rx_enable,
  input  logic       rx_in,
  output logic       rx_empty,
  output logic       rx_frame_err,
  output logic       rx_overrun
);
  logic tick;
  tx_state_e tx_st_q;
  logic [7:0] tx_sr_q;
  logic [3:0] tx_tc_q;
  logic [2:0] tx_bc_q;
  logic tx_out_q, tx_empty_q, tx_ack_q;
  rx_state_e rx_st_q;
  logic [1:0] rx_sync_q;
  logic [7:0] rx_sr_q, rx_data_q;
  logic [3:0] rx_tc_q;
  logic [2:0] rx_bc_q;
  logic rx_empty_q, rx_ferr_q, rx_ovr_q, uld_ack_q;
  logic rx_s, rx_done, rx_unload;

  uart_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .reset(reset), .tick(tick));

  assign ld_tx_ack = tx_ack_q;
  assign tx_out = tx_out_q;
  assign tx_empty = tx_empty_q;
  assign uld_rx_ack = uld_ack_q;
  assign rx_data = rx_data_q;
  assign rx_empty = rx_empty_q;
  assign rx_frame_err = rx_ferr_q;
  assign rx_overrun = rx_ovr_q;

  // T_START waits one tick with the line still high so the start bit aligns to the tick grid
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st_q <= T_IDLE;
      tx_sr_q <= '0;
      tx_tc_q <= '0;
      tx_bc_q <= '0;
      tx_out_q <= 1'b1;
      tx_empty_q <= 1'b1;
      tx_ack_q <= 1'b0;
    end else begin
      if (!ld_tx_req) tx_ack_q <= 1'b0;
      if (tx_st_q == T_IDLE) begin
        if (ld_tx_req && tx_enable && !tx_ack_q) begin
          tx_sr_q <= tx_data;
          tx_ack_q <= 1'b1;
          tx_empty_q <= 1'b0;
          tx_tc_q <= '0;
          tx_bc_q <= '0;
          tx_st_q <= T_START;
        end
      end else if (tick) begin
        tx_tc_q <= tx_tc_q + 1'b1;
        if (tx_st_q == T_START && tx_out_q) begin
          tx_out_q <= 1'b0;
          tx_tc_q <= '0;
        end else if (tx_tc_q == 4'(OVERSAMPLE - 1)) begin
          case (tx_st_q)
            T_START: begin
              tx_st_q <= T_DATA;
              tx_out_q <= tx_sr_q[0];
            end
            T_DATA: begin
              tx_bc_q <= tx_bc_q + 1'b1;
              tx_sr_q <= tx_sr_q >> 1;
              tx_out_q <= (tx_bc_q == 3'(DATA_BITS - 1)) ? 1'b1 : tx_sr_q[1];
              if (tx_bc_q == 3'(DATA_BITS - 1)) tx_st_q <= T_STOP;
            end
            default: begin
              tx_st_q <= T_IDLE;
              tx_empty_q <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign rx_s = rx_sync_q[1];
  assign rx_done = tick && rx_enable && rx_st_q == R_STOP && rx_tc_q == 4'(OVERSAMPLE - 1);
  assign rx_unload = uld_rx_req && !uld_ack_q;

  always_ff @(posedge clk) begin
    if (reset) rx_sync_q <= 2'b11;
    else rx_sync_q <= {rx_sync_q[0], rx_in};
  end

  always_ff @(posedge clk) begin
    if (reset || !rx_enable) begin
      rx_st_q <= R_IDLE;
      rx_tc_q <= '0;
      rx_bc_q <= '0;
      if (reset) rx_sr_q <= '0;
    end else if (tick) begin
      rx_tc_q <= rx_tc_q + 1'b1;
      case (rx_st_q)
        R_IDLE: begin
          rx_tc_q <= '0;
          if (!rx_s) rx_st_q <= R_START;
        end
        R_START: if (rx_tc_q == 4'(HALF_BIT - 1)) begin
          rx_st_q <= rx_s ? R_IDLE : R_DATA;
          rx_tc_q <= '0;
          rx_bc_q <= '0;
        end
        R_DATA: if (rx_tc_q == 4'(OVERSAMPLE - 1)) begin
          rx_sr_q <= {rx_s, rx_sr_q[7:1]};
          rx_bc_q <= rx_bc_q + 1'b1;
          if (rx_bc_q == 3'(DATA_BITS - 1)) rx_st_q <= R_STOP;
        end
        default: if (rx_tc_q == 4'(OVERSAMPLE - 1)) rx_st_q <= R_IDLE;
      endcase
    end
  end

  // A completing frame takes priority over a same-cycle unload for empty/overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      uld_ack_q <= 1'b0;
      rx_empty_q <= 1'b1;
      rx_data_q <= '0;
      rx_ferr_q <= 1'b0;
      rx_ovr_q <= 1'b0;
    end else begin
      if (!uld_rx_req) uld_ack_q <= 1'b0;
      if (rx_unload) begin
        uld_ack_q <= 1'b1;
        rx_empty_q <= 1'b1;
        rx_ovr_q <= 1'b0;
      end
      if (rx_done) begin
        rx_data_q <= rx_sr_q;
        rx_ferr_q <= !rx_s;
        rx_ovr_q <= !rx_unload && (rx_ovr_q || !rx_empty_q);
        rx_empty_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dl11_uart.sv
// tb_dl11_uart: randomized scoreboard bench for the DL11 UART core
module tb_dl11_uart;
  localparam int BIT = 64;
  logic clk = 0, reset = 1, ld_tx_req = 0, tx_enable = 1, uld_rx_req = 0, rx_enable = 1, rx_in = 1;
  logic [7:0] tx_data = 0;
  logic ld_tx_ack, tx_out, tx_empty, uld_rx_ack, rx_empty, rx_frame_err, rx_overrun;
  logic [7:0] rx_data;
  int total = 0, bad = 0;
  logic [7:0] tx_exp[$];
  logic [9:0] rx_exp[$];
  bit model_full = 0;
  logic [7:0] model_last = 0;

  always #5 clk = ~clk;

  dl11_uart #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .ld_tx_req(ld_tx_req), .ld_tx_ack(ld_tx_ack), .tx_data(tx_data),
    .tx_enable(tx_enable), .tx_out(tx_out), .tx_empty(tx_empty), .uld_rx_req(uld_rx_req),
    .uld_rx_ack(uld_rx_ack), .rx_data(rx_data), .rx_enable(rx_enable), .rx_in(rx_in),
    .rx_empty(rx_empty), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, want, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic was_idle, prev_empty;
    int n;
    tx_data = b;
    ld_tx_req = 1;
    was_idle = tx_empty;
    prev_empty = tx_empty;
    n = 0;
    @(posedge clk);
    @(negedge clk);
    while (!ld_tx_ack && n < 2000) begin
      prev_empty = tx_empty;
      @(negedge clk);
      n++;
    end
    check("tx_ack_seen", ld_tx_ack, 1);
    check("tx_ack_after_empty", prev_empty, 1);
    check("tx_empty_fall", tx_empty, 0);
    if (was_idle) check("tx_ack_latency", n, 0);
    tx_exp.push_back(b);
    step(1);
    ld_tx_req = 0;
    @(posedge clk);
    @(negedge clk);
    check("tx_ack_clear", ld_tx_ack, 0);
    step(1);
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while ((tx_exp.size() != 0 || !tx_empty) && n < 2000) begin
      step(1);
      n++;
    end
    check("tx_drain", tx_exp.size(), 0);
    step(4);
  endtask

  task automatic drive_frame(input logic [7:0] b, input bit stop_ok);
    rx_exp.push_back({model_full, !stop_ok, b});
    model_full = 1;
    model_last = b;
    rx_in = 0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      step(BIT);
    end
    if (stop_ok) begin
      rx_in = 1;
      step(BIT);
    end else begin
      rx_in = 0;
      step(48);
      rx_in = 1;
    end
    step(2 * BIT);
  endtask

  task automatic unload();
    uld_rx_req = 1;
    @(posedge clk);
    @(negedge clk);
    check("uld_ack", uld_rx_ack, 1);
    check("uld_empty", rx_empty, 1);
    check("uld_overrun", rx_overrun, 0);
    check("uld_data_hold", rx_data, model_last);
    model_full = 0;
    step(1);
    uld_rx_req = 0;
    @(posedge clk);
    @(negedge clk);
    check("uld_ack_clear", uld_rx_ack, 0);
    step(1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tx_out"}, tx_out, 1);
    check({tag, "_tx_empty"}, tx_empty, 1);
    check({tag, "_ld_tx_ack"}, ld_tx_ack, 0);
    check({tag, "_uld_rx_ack"}, uld_rx_ack, 0);
    check({tag, "_rx_empty"}, rx_empty, 1);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_rx_frame_err"}, rx_frame_err, 0);
    check({tag, "_rx_overrun"}, rx_overrun, 0);
  endtask

  // TX monitor: a plain UART receiver sampling each bit at its centre
  initial begin
    logic [9:0] bits;
    bit abort;
    int k;
    forever begin
      @(negedge clk);
      if (!reset && tx_out === 1'b0) begin
        abort = 0;
        for (int i = 0; i < 10 && !abort; i++) begin
          for (int j = 0; j < (i == 0 ? BIT / 2 : BIT) && !abort; j++) begin
            @(negedge clk);
            if (reset) abort = 1;
          end
          bits[i] = tx_out;
        end
        if (!abort) begin
          check("tx_start_bit", bits[0], 0);
          check("tx_stop_bit", bits[9], 1);
          check("tx_empty_busy", tx_empty, 0);
          check("tx_exp_avail", tx_exp.size() > 0, 1);
          if (tx_exp.size() > 0) check("tx_byte", bits[8:1], tx_exp.pop_front());
          k = 0;
          while (!tx_empty && k < 40) begin
            @(negedge clk);
            k++;
          end
          check("tx_empty_rise", tx_empty, 1);
        end
      end
    end
  end

  // RX monitor: a new held byte shows as rx_empty falling or the held state changing while full
  initial begin
    logic [9:0] prev, cur;
    logic pe;
    prev = 0;
    pe = 1;
    forever begin
      @(negedge clk);
      cur = {rx_overrun, rx_frame_err, rx_data};
      if (!reset && !rx_empty && (pe || cur != prev)) begin
        check("rx_exp_avail", rx_exp.size() > 0, 1);
        if (rx_exp.size() > 0) check("rx_frame", cur, rx_exp.pop_front());
      end
      prev = cur;
      pe = rx_empty;
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    step(3);
    @(negedge clk);
    check_reset_state("rst");
    step(1);
    reset = 0;
    step(5);
    send_byte(8'h55);
    wait_tx_idle();
    drive_frame(8'hA3, 1);
    unload();
    rx_in = 0;
    step(12);
    rx_in = 1;
    step(2 * BIT);
    check("glitch_empty", rx_empty, 1);
    check("glitch_no_frame", rx_exp.size(), 0);
    drive_frame(8'h41, 1);
    drive_frame(8'h42, 1);
    unload();
    drive_frame(8'h7E, 0);
    unload();
    send_byte(8'hFF);
    step(5 * BIT);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx_out", tx_out, 1);
    check("midrst_tx_empty", tx_empty, 1);
    check("midrst_ld_tx_ack", ld_tx_ack, 0);
    tx_exp.delete();
    model_full = 0;
    model_last = 0;
    step(1);
    reset = 0;
    step(3);
    send_byte(8'h3C);
    send_byte(8'hC3);
    wait_tx_idle();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_byte(b);
      drive_frame(8'($urandom), 1);
      unload();
      wait_tx_idle();
    end
    tx_enable = 0;
    ld_tx_req = 1;
    tx_data = 8'h99;
    step(20);
    check("tx_enable_block_ack", ld_tx_ack, 0);
    check("tx_enable_block_empty", tx_empty, 1);
    ld_tx_req = 0;
    tx_enable = 1;
    step(4);
    check("tx_queue_left", tx_exp.size(), 0);
    check("rx_queue_left", rx_exp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dl11_uart.md
# dl11_uart

Single-clock async serial core for the DL11 console path. It sits directly below the console register block: it consumes transmit bytes and produces receive bytes over four-phase req/ack handshakes, and drives/samples the RS-232 pins. Bit timing comes from an internal 16x oversample tick, so no separate baud clocks are needed. Framing is fixed 8N1.

## Interface
- `CLK_DIV`, default 27: `clk` cycles per 16x oversample tick; must be ≥2. Bit period = 16·`CLK_DIV` clocks.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ld_tx_req` in 1: transmit load request, held until `ld_tx_ack` rises.
- `ld_tx_ack` out 1: transmit load acknowledge.
- `tx_data` in 8: byte to send; sampled on the acceptance cycle.
- `tx_enable` in 1: allows new loads to be accepted.
- `tx_out` out 1: serial output, idle high.
- `tx_empty` out 1: high when no character is loaded or shifting.
- `uld_rx_req` in 1: receive unload request.
- `uld_rx_ack` out 1: receive unload acknowledge.
- `rx_data` out 8: receive holding register.
- `rx_enable` in 1: receiver run enable.
- `rx_in` in 1: serial input; asynchronous.
- `rx_empty` out 1: high when the holding register has no unread byte.
- `rx_frame_err` out 1: stop bit of the last held byte sampled low.
- `rx_overrun` out 1: a byte arrived while the holding register was full.

## Operation
- **Tick generator.** A counter runs 0..`CLK_DIV`-1 and emits a 1-cycle `tick` at wrap. It runs freely and is cleared by reset.
- **TX FSM states:** T_IDLE, T_START, T_DATA, T_STOP.
  - In T_IDLE, if `ld_tx_req` & `tx_enable` & !`ld_tx_ack`: latch `tx_data` into the shift register, set `ld_tx_ack`=1, set `tx_empty`=0, go to T_START.
  - `ld_tx_ack` clears on the first clock where `ld_tx_req`=0.
  - Each state lasts 16 ticks. `tx_out` is 0 in T_START, LSB-first data bits in T_DATA (8 bits, 3-bit counter), and 1 in T_STOP.
  - At the end of T_STOP, go to T_IDLE and set `tx_empty`=1.
  - While not idle, requests wait; acceptance occurs only in T_IDLE.
  - `tx_enable` low blocks acceptance only; a character in flight completes.
- **RX input.** `rx_in` passes through a 2-flop synchronizer (reset value 1).
- **RX FSM states:** R_IDLE, R_START, R_DATA, R_STOP.
  - In R_IDLE, a low synchronized input on a tick goes to R_START.
  - In R_START, after 8 ticks re-sample: if high (glitch), return to R_IDLE; if low, go to R_DATA.
  - In R_DATA, sample every 16 ticks (bit centre) into the shift register, LSB first, 8 bits.
  - In R_STOP, sample at 16 ticks, then:
    - copy the shift register to `rx_data`;
    - `rx_frame_err` = !stop;
    - `rx_overrun` = !`rx_empty`. The old byte is overwritten and the flag is sticky until the next unload.
    - set `rx_empty`=0;
    - go to R_IDLE.
  - `rx_enable` low forces R_IDLE and abandons a partial frame. The holding register is unaffected.
- **RX unload.** If `uld_rx_req` & !`uld_rx_ack`: set `uld_rx_ack`=1, `rx_empty`=1, clear `rx_overrun`. `rx_data` holds its value. `uld_rx_ack` clears on the first clock with `uld_rx_req`=0.
  - If unload acceptance and frame completion occur in the same cycle, the new byte is loaded, `rx_empty` stays 0, and `rx_overrun` is 0.

## Timing
- Reset values:
  - `tx_out`=1, `tx_empty`=1, `ld_tx_ack`=0.
  - `uld_rx_ack`=0, `rx_empty`=1, `rx_data`=0, `rx_frame_err`=0, `rx_overrun`=0.
  - Both FSMs idle; tick counter 0.
- Reset mid-frame aborts immediately; `tx_out` returns to 1 the following cycle.
- `ld_tx_ack` rises 1 clock after `ld_tx_req` is sampled high (when idle and enabled). `tx_empty` falls on the same edge. The start bit begins at the next tick.
- `tx_empty` rises 16·10 ticks after the start bit begins.
- `uld_rx_ack` rises 1 clock after request; `rx_empty` rises on the same edge.
- `rx_empty` falls on the clock after the stop-bit sample tick. Nominal latency is ~9.5 bit periods plus 2 synchronizer clocks plus tick phase.
- All outputs are registered.

## Structure
- Shared package/include holds:
  - TX and RX state encodings (2 bits each);
  - `OVERSAMPLE`=16, `HALF_BIT`=8, `DATA_BITS`=8.
- Sub-module `uart_tick_gen` (parameter `CLK_DIV`; ports `clk`, `reset`, `tick`). TX and RX share one instance.
- TX and RX FSMs live in this module as separate always blocks with independent counters.

## Test plan
All scenarios use `CLK_DIV`=4, so 64 clocks per bit.
1. Send 0x55 via req/ack.
   - Expect: ack 1 clock after req, `tx_empty` falls with it.
   - `tx_out` shows 0,1,0,1,0,1,0,1,0,1, each 64±4 clocks.
   - `tx_empty` rises after the stop bit.
2. Drive an 8N1 frame of 0xA3 on `rx_in`.
   - Expect: `rx_empty` falls, `rx_data`=0xA3, `rx_frame_err`=0.
   - After unload: `rx_empty`=1, `rx_data` still 0xA3.
3. Drive a 3-tick low glitch on `rx_in`.
   - Expect: receiver back to R_IDLE, `rx_empty` stays 1.
4. Send 0x41 then 0x42 without unloading.
   - Expect: `rx_data`=0x42 and `rx_overrun`=1.
   - Unload clears `rx_overrun` to 0.
5. Send a frame 0x7E with stop bit low.
   - Expect: `rx_frame_err`=1 and `rx_data`=0x7E.
6. Assert `reset` halfway through transmitting 0xFF.
   - Expect: next cycle `tx_out`=1, `tx_empty`=1, `ld_tx_ack`=0.
   - A new request afterwards is accepted normally.
   - Also hold `ld_tx_req` during a shift: ack is withheld until `tx_empty`=1.
